// File: rtl/mem_bus_arbiter.sv
// Two-requester (DMA, CPU) arbiter for the single memory port; grants are held until mem_ok.
// Optional ARB_ROUND_ROBIN_EN replaces fixed DMA priority + burst limiter with alternating priority.
module mem_bus_arbiter #(
    parameter int MAX_DMA_BURST = 16,
    parameter int CNT_W         = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_width,
    input  logic        cpu_we,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [1:0]  dma_width,
    input  logic        dma_we,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  mem_width,
    output logic        mem_read,
    output logic        mem_write,
    input  logic        mem_ok,
    output logic        grant_dma
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_DMA = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   arb_point;
    logic   pick_dma;

    // A new winner is chosen every idle cycle and on the completing cycle of a grant.
    assign arb_point = (state == IDLE) || mem_ok;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_dma;

    assign pick_dma = dma_req && (!cpu_req || !last_dma);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_dma <= 1'b0;
        end else if (arb_point && state_next == GNT_DMA) begin
            last_dma <= 1'b1;
        end else if (arb_point && state_next == GNT_CPU) begin
            last_dma <= 1'b0;
        end
    end
`else
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
        cnt_next = cnt;
        if (!cpu_req) begin
            cnt_next = '0;
        end else if (state == GNT_CPU && mem_ok) begin
            cnt_next = '0;
        end else if (state == GNT_DMA && mem_ok && cnt != CNT_W'(MAX_DMA_BURST)) begin
            cnt_next = cnt + 1'b1;
        end
    end

    // The decision sees the count including the DMA transaction completing this cycle.
    assign pick_dma = dma_req &&
                      !(cpu_req && (MAX_DMA_BURST != 0) && cnt_next == CNT_W'(MAX_DMA_BURST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end
`endif

    always_comb begin
        state_next = state;
        if (arb_point) begin
            if (pick_dma) begin
                state_next = GNT_DMA;
            end else if (cpu_req) begin
                state_next = GNT_CPU;
            end else begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign grant_dma = (state == GNT_DMA);

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_width = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        cpu_ack   = 1'b0;
        cpu_rdata = '0;
        dma_ack   = 1'b0;
        dma_rdata = '0;
        case (state)
            GNT_CPU: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_width = cpu_width;
                mem_read  = ~cpu_we;
                mem_write = cpu_we;
                cpu_ack   = mem_ok;
                cpu_rdata = mem_ok ? mem_rdata : '0;
            end
            GNT_DMA: begin
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                mem_width = dma_width;
                mem_read  = ~dma_we;
                mem_write = dma_we;
                dma_ack   = mem_ok;
                dma_rdata = mem_ok ? mem_rdata : '0;
            end
            default: ;
        endcase
    end

endmodule
